// File: rtl/data_mem_rmw_pkg.sv
// data_mem_rmw_pkg: shared types and constants for the data memory store sequencer
package data_mem_rmw_pkg;
    typedef enum logic {IDLE, RMW} rmw_state_t;
    localparam int BYTE_LANES = 4;
    localparam int LANE_BITS = 2;
    localparam logic ST_WORD = 1'b0;
    localparam logic ST_BYTE = 1'b1;
endpackage

// File: rtl/data_mem_rmw_byte_lane_merge.sv
// byte_lane_merge: replaces one byte lane of a word, leaving the other lanes untouched
module byte_lane_merge
    import data_mem_rmw_pkg::*;
(
    input  logic [8*BYTE_LANES-1:0] word,
    input  logic [7:0]              data_byte,
    input  logic [LANE_BITS-1:0]    lane,
    output logic [8*BYTE_LANES-1:0] merged
);
    for (genvar i = 0; i < BYTE_LANES; i++) begin : g_lane
        assign merged[8*i +: 8] = (lane == LANE_BITS'(i)) ? data_byte : word[8*i +: 8];
    end
endmodule

// File: rtl/data_mem_rmw.sv
// data_mem_rmw: word data memory with single-cycle word stores and RMW byte stores; MISALIGN_TRAP_EN enables misaligned word-access trapping
module data_mem_rmw
    import data_mem_rmw_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic                  StSrc,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);
    localparam int DEPTH = 1 << WORD_ADDR_BITS;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    rmw_state_t state;
    logic [WORD_ADDR_BITS-1:0] idx, idx_q;
    logic [LANE_BITS-1:0] lane_q;
    logic [7:0] byte_q;
    logic [DATA_WIDTH-1:0] old_q, merged;
    logic accept, is_load, is_sw, is_sb, mis, unused_bits;
    assign idx = A[WORD_ADDR_BITS+1:2];
    assign accept = req_valid && state == IDLE;
    assign is_load = accept && !req_we;
    assign is_sw = accept && req_we && StSrc == ST_WORD;
    assign is_sb = accept && req_we && StSrc == ST_BYTE;
    assign busy = state == RMW;
    assign unused_bits = ^A[ADDR_WIDTH-1:WORD_ADDR_BITS+2];
`ifdef MISALIGN_TRAP_EN
    assign mis = StSrc == ST_WORD && A[1:0] != '0;
    always_ff @(posedge clk) begin
        err <= !rst && accept && mis;
    end
`else
    assign mis = 1'b0;
    assign err = 1'b0;
`endif
    byte_lane_merge u_merge (
        .word     (old_q),
        .data_byte(byte_q),
        .lane     (lane_q),
        .merged   (merged)
    );
    // Writes commit at the edge before a following load reads, so back-to-back loads see new data
    always_ff @(posedge clk) begin
        if (!rst && is_sw && !mis) mem[idx] <= WD;
        if (!rst && state == RMW) mem[idx_q] <= merged;
        if (is_sb) begin
            old_q  <= mem[idx];
            idx_q  <= idx;
            lane_q <= A[1:0];
            byte_q <= WD[7:0];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            RD       <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= is_sb ? RMW : IDLE;
            rd_valid <= is_load;
            if (is_load) RD <= mis ? '0 : mem[idx];
        end
    end
endmodule

// File: tb/tb_data_mem_rmw.sv
// tb_data_mem_rmw: table-driven directed test of data_mem_rmw plus reset-in-RMW and misalignment sequences
module tb_data_mem_rmw;
    logic clk = 1'b0;
    logic rst, req_valid, req_we, StSrc;
    logic [31:0] A, WD, RD;
    logic rd_valid, busy, err;
    int total = 0;
    int bad = 0;
    typedef struct packed {
        logic v, we, sb;
        logic [31:0] a, wd;
        logic erv, ebusy;
        logic [31:0] erd;
    } vec_t;
    vec_t vt[$];
    always #5 clk = ~clk;
    data_mem_rmw dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .StSrc(StSrc),
        .A(A), .WD(WD), .RD(RD), .rd_valid(rd_valid), .busy(busy), .err(err)
    );
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic v, input logic we, input logic sb, input logic [31:0] a, input logic [31:0] wd);
        req_valid = v; req_we = we; StSrc = sb; A = a; WD = wd;
    endtask
    task automatic add(input logic v, input logic we, input logic sb, input logic [31:0] a,
                       input logic [31:0] wd, input logic erv, input logic ebusy, input logic [31:0] erd);
        vt.push_back({v, we, sb, a, wd, erv, ebusy, erd});
    endtask
    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        cyc(); cyc();
        chk("reset_rd", RD, 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err), 0);
        rst = 1'b0;
        //  v we sb addr       wd            rv busy rd
        add(1, 1, 0, 32'h10,   32'hDEADBEEF, 0, 0, 32'h0);
        add(1, 0, 0, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF);
        add(1, 1, 1, 32'h12,   32'h000000A5, 0, 1, 32'hDEADBEEF);
        add(0, 0, 0, 32'h0,    32'h0,        0, 0, 32'hDEADBEEF);
        add(1, 0, 0, 32'h10,   32'h0,        1, 0, 32'hDEA5BEEF);
        add(1, 1, 0, 32'h20,   32'h0,        0, 0, 32'hDEA5BEEF);
        add(1, 1, 1, 32'h20,   32'h11,       0, 1, 32'hDEA5BEEF);
        add(0, 0, 0, 32'h0,    32'h0,        0, 0, 32'hDEA5BEEF);
        add(1, 1, 1, 32'h21,   32'h22,       0, 1, 32'hDEA5BEEF);
        add(0, 0, 0, 32'h0,    32'h0,        0, 0, 32'hDEA5BEEF);
        add(1, 1, 1, 32'h22,   32'hFFFFFF33, 0, 1, 32'hDEA5BEEF);
        add(0, 0, 0, 32'h0,    32'h0,        0, 0, 32'hDEA5BEEF);
        add(1, 1, 1, 32'h23,   32'h44,       0, 1, 32'hDEA5BEEF);
        add(0, 0, 0, 32'h0,    32'h0,        0, 0, 32'hDEA5BEEF);
        add(1, 0, 0, 32'h20,   32'h0,        1, 0, 32'h44332211);
        add(1, 1, 0, 32'h30,   32'h12345678, 0, 0, 32'h44332211);
        add(1, 0, 0, 32'h30,   32'h0,        1, 0, 32'h12345678);
        add(1, 1, 1, 32'h31,   32'hAB,       0, 1, 32'h12345678);
        add(1, 0, 0, 32'h30,   32'h0,        0, 0, 32'h12345678);
        add(1, 0, 0, 32'h30,   32'h0,        1, 0, 32'h1234AB78);
        add(1, 1, 1, 32'h13,   32'h77,       0, 1, 32'h1234AB78);
        add(0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h1234AB78);
        add(1, 0, 0, 32'h10,   32'h0,        1, 0, 32'h77A5BEEF);
        add(0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h77A5BEEF);
        add(1, 1, 0, 32'h1010, 32'hCAFEF00D, 0, 0, 32'h77A5BEEF);
        add(1, 0, 0, 32'h10,   32'h0,        1, 0, 32'hCAFEF00D);
        add(1, 1, 0, 32'hFFC,  32'h0BADF00D, 0, 0, 32'hCAFEF00D);
        add(1, 0, 0, 32'hF0000FFC, 32'h0,    1, 0, 32'h0BADF00D);
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].v, vt[i].we, vt[i].sb, vt[i].a, vt[i].wd);
            cyc();
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].erv));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].ebusy));
            chk($sformatf("vec%0d_rd", i), RD, vt[i].erd);
            chk($sformatf("vec%0d_err", i), 32'(err), 0);
        end
        // reset during the RMW cycle aborts the write-back
        drive(1, 1, 0, 32'h40, 32'h55AA55AA); cyc();
        drive(1, 1, 1, 32'h40, 32'hFF); cyc();
        chk("rst_rmw_busy_before", 32'(busy), 1);
        rst = 1'b1; drive(0, 0, 0, 0, 0); cyc();
        rst = 1'b0;
        chk("rst_rmw_busy", 32'(busy), 0);
        chk("rst_rmw_rd", RD, 0);
        chk("rst_rmw_rd_valid", 32'(rd_valid), 0);
        drive(1, 0, 0, 32'h40, 0); cyc();
        chk("rst_rmw_lw_valid", 32'(rd_valid), 1);
        chk("rst_rmw_lw_rd", RD, 32'h55AA55AA);
        // misaligned word accesses
        drive(1, 1, 0, 32'h41, 32'hFFFFFFFF); cyc();
`ifdef MISALIGN_TRAP_EN
        chk("mis_sw_err", 32'(err), 1);
`else
        chk("mis_sw_err", 32'(err), 0);
`endif
        drive(0, 0, 0, 0, 0); cyc();
        chk("mis_err_clear", 32'(err), 0);
        drive(1, 0, 0, 32'h42, 0); cyc();
        chk("mis_lw_valid", 32'(rd_valid), 1);
`ifdef MISALIGN_TRAP_EN
        chk("mis_lw_err", 32'(err), 1);
        chk("mis_lw_rd", RD, 0);
`else
        chk("mis_lw_err", 32'(err), 0);
        chk("mis_lw_rd", RD, 32'hFFFFFFFF);
`endif
        drive(1, 1, 1, 32'h41, 32'h00); cyc();
        chk("mis_sb_err", 32'(err), 0);
        chk("mis_sb_busy", 32'(busy), 1);
        drive(0, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 32'h40, 0); cyc();
`ifdef MISALIGN_TRAP_EN
        chk("mis_after_rd", RD, 32'h55AA00AA);
`else
        chk("mis_after_rd", RD, 32'hFFFF00FF);
`endif
        drive(0, 0, 0, 0, 0); cyc();
        chk("idle_rd_valid", 32'(rd_valid), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_rmw.md
Name: data_mem_rmw

Overview:
Word-organised data memory with a store sequencer. Sits directly downstream of the store-data correction stage and receives its corrected write data.
- Word stores (SW) are written in a single cycle.
- Byte stores (SB) run a read-modify-write through a small FSM. The block stalls the pipeline for one cycle, merges the byte into the lane selected by A[1:0], and writes the word back.
- Loads return the full aligned word one cycle after acceptance.

Parameters:
DATA_WIDTH, 32, width of data words (fixed 32; byte lanes assume 4 lanes)
ADDR_WIDTH, 32, width of the byte address A
WORD_ADDR_BITS, 10, log2 of memory depth in words; word index = A[WORD_ADDR_BITS+1:2]

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  memory request present this cycle
req_we  input  1  1: store, 0: load
StSrc  input  1  store size; 0: word, 1: byte
A  input  ADDR_WIDTH  byte address
WD  input  DATA_WIDTH  store data; byte stores use WD[7:0]
RD  output  DATA_WIDTH  registered load data (full aligned word)
rd_valid  output  1  RD holds data for the load accepted in the previous cycle
busy  output  1  block is mid read-modify-write; upstream holds request, pipeline stalls
err  output  1  misaligned access flag (MISALIGN_TRAP_EN only, else tied 0)

Behaviour:
- Reset (sync, active-high): state=IDLE, RD=0, rd_valid=0, busy=0, err=0. Memory array contents are not reset.
- Handshake:
  - A request is accepted when req_valid=1 and state=IDLE.
  - busy = (state != IDLE), driven from the register, not combinational.
  - Requests presented while busy=1 are ignored. Upstream holds them until busy=0.
- Load:
  - Accepted in cycle N; the array is read synchronously.
  - RD = mem[word index] and rd_valid=1 in cycle N+1.
  - rd_valid=0 in any cycle not following an accepted load; RD holds its last value.
- Word store: accepted in cycle N; mem[word index] = WD at the end of cycle N. No stall.
- Byte store:
  - Cycle N (IDLE): accept. Issue the array read, latch the lane (A[1:0]), the word index and WD[7:0]. Next state is RMW.
  - Cycle N+1 (RMW): busy=1. Merge the latched byte into bits [8*lane+7:8*lane] of the read word; other lanes are unchanged. Write the word back at the end of N+1. Next state is IDLE.
  - Total SB occupancy is 2 cycles.
- Read-during-write bypass: a load accepted in the cycle immediately after a store to the same word index returns the newly written word, not stale data.
- Reset asserted while in RMW: the write is aborted and memory is unchanged. Next state is IDLE.
- req_valid=0 in IDLE: no array access. rd_valid=0 next cycle.
- Address bits above WORD_ADDR_BITS+1 are ignored; the address wraps modulo the memory size.
- FSM states: IDLE, RMW. Encoding uses a 1-bit enum.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A word load or word store with A[1:0] != 0 sets err=1 for one cycle (N+1).
  - A store of this kind does not write memory.
  - A load of this kind returns RD=0 with rd_valid=1.
  - Byte accesses never trap.
- Undefined: A[1:0] is ignored for word accesses (truncated to the aligned word) and err is tied 0.

Decomposition:
- Shared package (memory types):
  - rmw_state_t enum {IDLE, RMW}
  - BYTE_LANES = 4
  - LANE_BITS = 2
  - store size localparams ST_WORD = 0, ST_BYTE = 1
- One natural sub-module: byte_lane_merge. It is combinational and takes {old word, byte, lane} to produce the merged word. It is reused for future halfword support.
- The array, FSM and bypass live in the top module.

Test Plan:
- Reset, then SW A=0x10 WD=0xDEADBEEF, then LW A=0x10 -> rd_valid=1 next cycle, RD=0xDEADBEEF, busy never high.
- Word 0x10=0xDEADBEEF, then SB A=0x12 WD=0x000000A5 -> busy=1 exactly one cycle. A following LW 0x10 returns 0xDEA5BEEF.
- SB to lanes 0..3 of A=0x20 (initially 0) with bytes 0x11,0x22,0x33,0x44, then LW 0x20 -> RD=0x44332211. Each SB shows 2-cycle occupancy.
- SW A=0x30 WD=0x12345678 in cycle N, LW A=0x30 in cycle N+1 -> RD=0x12345678 (bypass). Request held during busy is accepted only once busy=0.
- SB A=0x40 accepted, rst=1 during RMW cycle -> busy=0, RD=0, rd_valid=0 next cycle; LW 0x40 returns prior contents unchanged.
- With MISALIGN_TRAP_EN: SW A=0x41 WD=0xFFFFFFFF -> err=1 one cycle, LW 0x40 unchanged. Without the macro: the same store writes word 0x40, err stays 0.
